control_unit: RTL

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_pkg.sv | 54 +++++
 rtl/control_unit_if.sv | 35 +++
 rtl/control_unit_decode.sv | 31 +++
 rtl/control_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, FSM states,
// instruction classes and the internal strobe bundle.
package control_unit_pkg;

  localparam int OPC_W = 5;
  typedef logic [OPC_W-1:0] opcode_t;

  localparam opcode_t OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,
                      OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,
                      OP_OR   = 5'd6,  OP_ROR  = 5'd7,  OP_ROL  = 5'd8,
                      OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11,
                      OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14,
                      OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17,
                      OP_NOT  = 5'd18, OP_BR   = 5'd19, OP_JR   = 5'd20,
                      OP_IN   = 5'd22, OP_OUT  = 5'd23, OP_MFHI = 5'd24,
                      OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

  // The ALU decodes the opcode itself, so ALU codes share opcode values.
  localparam opcode_t ALU_NONE = 5'd0;
  localparam opcode_t ALU_ADD  = OP_ADD;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
    S_T4    = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_RR, C_ALU_IMM, C_MULDIV, C_UNARY, C_LD, C_LDI, C_ST, C_BR,
    C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
  } iclass_t;

  typedef struct packed {
    logic    pc_out, mar_en, inc_pc, zlow_in, zhigh_in, zlow_out, zhigh_out;
    logic    pc_en, mdr_read, mdr_en, mdr_out, ir_en, ram_write;
    logic    gra, grb, grc, r_in, r_out, ba_out, c_out, y_en, con_en;
    logic    hi_en, lo_en, hi_out, lo_out, inport_out, outport_en;
    opcode_t alu_op;
    logic    run;
  } ctrl_t;

  // Final T step of each instruction class.
  function automatic state_t last_step(input iclass_t c);
    case (c)
      C_UNARY:                     return S_T4;
      C_ALU_RR, C_ALU_IMM, C_LDI:  return S_T5;
      C_MULDIV, C_BR:              return S_T6;
      C_LD, C_ST:                  return S_T7;
      default:                     return S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/condition/halt inputs and
// every control strobe the datapath consumes.
interface control_unit_if #(
  parameter int IR_W = 32,
  parameter int OP_W = 5
);
  logic [IR_W-1:0] IR;
  logic            CON_FF;
  logic            Stop;

  logic PCout, MAR_enable, IncPC, ZLowIn, ZHighIn, ZLowout, ZHighout;
  logic PC_enable, MDR_read, MDR_enable, MDRout, IR_enable, RAM_write;
  logic Gra, Grb, Grc, R_in, R_out, BAout, Cout, Y_enable, CON_enable;
  logic HI_enable, LO_enable, HIout, LOout, InPortout, OutPort_enable;
  logic [OP_W-1:0] ALU_op;
  logic            Run;

  modport master (
    input  IR, CON_FF, Stop,
    output PCout, MAR_enable, IncPC, ZLowIn, ZHighIn, ZLowout, ZHighout,
           PC_enable, MDR_read, MDR_enable, MDRout, IR_enable, RAM_write,
           Gra, Grb, Grc, R_in, R_out, BAout, Cout, Y_enable, CON_enable,
           HI_enable, LO_enable, HIout, LOout, InPortout, OutPort_enable,
           ALU_op, Run
  );

  modport slave (
    output IR, CON_FF, Stop,
    input  PCout, MAR_enable, IncPC, ZLowIn, ZHighIn, ZLowout, ZHighout,
           PC_enable, MDR_read, MDR_enable, MDRout, IR_enable, RAM_write,
           Gra, Grb, Grc, R_in, R_out, BAout, Cout, Y_enable, CON_enable,
           HI_enable, LO_enable, HIout, LOout, InPortout, OutPort_enable,
           ALU_op, Run
  );
endinterface

// File: rtl/control_unit_decode.sv
// Combinational opcode classifier; unassigned opcodes behave as nop.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  opcode_t opcode,
  output iclass_t iclass
);

  always_comb begin
    iclass = C_NOP;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
      OP_SHRA, OP_SHL, OP_ROR, OP_ROL:      iclass = C_ALU_RR;
      OP_ADDI, OP_ANDI, OP_ORI:             iclass = C_ALU_IMM;
      OP_MUL, OP_DIV:                       iclass = C_MULDIV;
      OP_NEG, OP_NOT:                       iclass = C_UNARY;
      OP_LD:                                iclass = C_LD;
      OP_LDI:                               iclass = C_LDI;
      OP_ST:                                iclass = C_ST;
      OP_BR:                                iclass = C_BR;
      OP_JR:                                iclass = C_JR;
      OP_IN:                                iclass = C_IN;
      OP_OUT:                               iclass = C_OUT;
      OP_MFHI:                              iclass = C_MFHI;
      OP_MFLO:                              iclass = C_MFLO;
      OP_HALT:                              iclass = C_HALT;
      default:                              iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Moore-style sequencer: fetch in T0-T2, class-specific execute steps in
// T3-T7, with halt via the halt opcode or a deferred Stop request.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int IR_W = 32,
  parameter int OP_W = 5
) (
  input  logic Clock,
  input  logic Clear,
  control_unit_if.master cu
);

  state_t  state, state_nx;
  logic    stop_pending, stop_nx;
  logic    in_t, instr_end;
  opcode_t opcode;
  iclass_t iclass;
  ctrl_t   c;
  logic    ir_unused;

  assign opcode    = opcode_t'(cu.IR[IR_W-1 -: OP_W]);
  assign ir_unused = ^cu.IR[IR_W-OP_W-1:0];

  control_unit_decode u_decode (
    .opcode (opcode),
    .iclass (iclass)
  );

  assign in_t      = (state >= S_T0) && (state <= S_T7);
  // ">=" keeps the sequence bounded even if IR changes mid-instruction.
  assign instr_end = (state >= S_T3) && ((state >= last_step(iclass)) || (state == S_T7));

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state        <= S_RESET;
      stop_pending <= 1'b0;
    end else begin
      state        <= state_nx;
      stop_pending <= stop_nx;
    end
  end

  // Stop is remembered and only acted on when the current instruction ends.
  always_comb begin
    state_nx = state;
    stop_nx  = stop_pending | (in_t & cu.Stop);
    case (state)
      S_RESET: state_nx = S_T0;
      S_HALT:  state_nx = S_HALT;
      default: begin
        if (instr_end)
          state_nx = ((iclass == C_HALT) || stop_nx) ? S_HALT : S_T0;
        else
          state_nx = state_t'(state + 4'd1);
      end
    endcase
  end

  always_comb begin
    c     = '0;
    c.run = in_t;
    case (state)
      S_T0: begin c.pc_out = 1'b1; c.mar_en = 1'b1; c.inc_pc = 1'b1; c.zlow_in = 1'b1; end
      S_T1: begin c.zlow_out = 1'b1; c.pc_en = 1'b1; c.mdr_read = 1'b1; c.mdr_en = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_en = 1'b1; end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        case (iclass)
          C_ALU_RR, C_ALU_IMM: begin
            case (state)
              S_T3: begin c.grb = 1'b1; c.r_out = 1'b1; c.y_en = 1'b1; end
              S_T4: begin
                c.alu_op  = opcode;
                c.zlow_in = 1'b1;
                if (iclass == C_ALU_IMM) c.c_out = 1'b1;
                else begin c.grc = 1'b1; c.r_out = 1'b1; end
              end
              S_T5: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
              default: ;
            endcase
          end
          C_MULDIV: begin
            case (state)
              S_T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_en = 1'b1; end
              S_T4: begin
                c.grb = 1'b1; c.r_out = 1'b1; c.alu_op = opcode;
                c.zhigh_in = 1'b1; c.zlow_in = 1'b1;
              end
              S_T5: begin c.zlow_out = 1'b1; c.lo_en = 1'b1; end
              S_T6: begin c.zhigh_out = 1'b1; c.hi_en = 1'b1; end
              default: ;
            endcase
          end
          C_UNARY: begin
            case (state)
              S_T3: begin c.grb = 1'b1; c.r_out = 1'b1; c.alu_op = opcode; c.zlow_in = 1'b1; end
              S_T4: begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
              default: ;
            endcase
          end
          C_LD, C_LDI, C_ST: begin
            case (state)
              S_T3: begin c.grb = 1'b1; c.ba_out = 1'b1; c.y_en = 1'b1; end
              S_T4: begin c.c_out = 1'b1; c.alu_op = ALU_ADD; c.zlow_in = 1'b1; end
              S_T5: begin
                c.zlow_out = 1'b1;
                if (iclass == C_LDI) begin c.gra = 1'b1; c.r_in = 1'b1; end
                else c.mar_en = 1'b1;
              end
              S_T6: begin
                c.mdr_en = 1'b1;
                if (iclass == C_ST) begin c.gra = 1'b1; c.r_out = 1'b1; end
                else c.mdr_read = 1'b1;
              end
              S_T7: begin
                if (iclass == C_ST) c.ram_write = 1'b1;
                else begin c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
              end
              default: ;
            endcase
          end
          C_BR: begin
            case (state)
              S_T3: begin c.gra = 1'b1; c.r_out = 1'b1; c.con_en = 1'b1; end
              S_T4: begin c.pc_out = 1'b1; c.y_en = 1'b1; end
              S_T5: begin c.c_out = 1'b1; c.alu_op = ALU_ADD; c.zlow_in = 1'b1; end
              S_T6: begin c.zlow_out = 1'b1; c.pc_en = cu.CON_FF; end
              default: ;
            endcase
          end
          C_JR:   if (state == S_T3) begin c.gra = 1'b1; c.r_out = 1'b1; c.pc_en = 1'b1; end
          C_IN:   if (state == S_T3) begin c.inport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_OUT:  if (state == S_T3) begin c.gra = 1'b1; c.r_out = 1'b1; c.outport_en = 1'b1; end
          C_MFHI: if (state == S_T3) begin c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MFLO: if (state == S_T3) begin c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign cu.PCout          = c.pc_out;
  assign cu.MAR_enable     = c.mar_en;
  assign cu.IncPC          = c.inc_pc;
  assign cu.ZLowIn         = c.zlow_in;
  assign cu.ZHighIn        = c.zhigh_in;
  assign cu.ZLowout        = c.zlow_out;
  assign cu.ZHighout       = c.zhigh_out;
  assign cu.PC_enable      = c.pc_en;
  assign cu.MDR_read       = c.mdr_read;
  assign cu.MDR_enable     = c.mdr_en;
  assign cu.MDRout         = c.mdr_out;
  assign cu.IR_enable      = c.ir_en;
  assign cu.RAM_write      = c.ram_write;
  assign cu.Gra            = c.gra;
  assign cu.Grb            = c.grb;
  assign cu.Grc            = c.grc;
  assign cu.R_in           = c.r_in;
  assign cu.R_out          = c.r_out;
  assign cu.BAout          = c.ba_out;
  assign cu.Cout           = c.c_out;
  assign cu.Y_enable       = c.y_en;
  assign cu.CON_enable     = c.con_en;
  assign cu.HI_enable      = c.hi_en;
  assign cu.LO_enable      = c.lo_en;
  assign cu.HIout          = c.hi_out;
  assign cu.LOout          = c.lo_out;
  assign cu.InPortout      = c.inport_out;
  assign cu.OutPort_enable = c.outport_en;
  assign cu.ALU_op         = OP_W'(c.alu_op);
  assign cu.Run            = c.run;

endmodule
